// File: rtl/spw_tx_data_sched_if.sv
// Bus bundle for spw_tx_data_sched: Avalon-MM slave side plus the SpaceWire TX character handshake.
// The master modport is the environment (Nios bus and link TX); the slave modport is the scheduler.
interface spw_tx_data_sched_if;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [8:0]  tx_data;
    logic        tx_write;
    logic        tx_ready;

    modport slave (
        input  address, chipselect, write_n, writedata, tx_ready,
        output readdata, tx_data, tx_write
    );

    modport master (
        output address, chipselect, write_n, writedata, tx_ready,
        input  readdata, tx_data, tx_write
    );
endinterface

// File: rtl/spw_tx_data_sched.sv
// SpaceWire TX character scheduler: Avalon-MM writes fill a 9-bit FIFO that drains onto the link TX handshake.
// Optional feature macro SPW_TX_FIFO_IRQ_EN adds the irq port and the CTRL irq_en bit.
module spw_tx_data_sched #(
    parameter int FIFO_DEPTH = 16,
    parameter int AW         = 4
) (
    input  logic clk,
    input  logic reset_n,
    spw_tx_data_sched_if.slave bus
`ifdef SPW_TX_FIFO_IRQ_EN
    ,
    output logic irq
`endif
);
    localparam logic [0:0]  ST_IDLE  = 1'b0;
    localparam logic [0:0]  ST_SEND  = 1'b1;
    localparam logic [AW:0] LVL_FULL = (AW+1)'(FIFO_DEPTH);
    localparam logic [AW:0] LVL_ZERO = (AW+1)'(0);
    localparam logic [AW:0] LVL_ONE  = (AW+1)'(1);

    logic [8:0]    mem_r [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [AW:0]   level_r;
    logic [0:0]    state_r;
    logic [8:0]    tx_data_r;
    logic          enable_r;
    logic          overflow_r;
    logic          irq_en_s;

    logic          wr_en_s;
    logic          push_req_s;
    logic          push_s;
    logic          pop_s;
    logic          flush_s;
    logic          ctrl_wr_s;
    logic          ovf_clr_s;
    logic          empty_s;
    logic          full_s;
    logic          hs_s;
    logic [31:0]   rdata_s;
    logic          unused_s;

    assign wr_en_s    = bus.chipselect && !bus.write_n;
    assign push_req_s = wr_en_s && (bus.address == 2'd0);
    assign ctrl_wr_s  = wr_en_s && (bus.address == 2'd2);
    assign ovf_clr_s  = wr_en_s && (bus.address == 2'd1) && bus.writedata[2];
    assign flush_s    = ctrl_wr_s && bus.writedata[1];
    assign empty_s    = (level_r == LVL_ZERO);
    assign full_s     = (level_r == LVL_FULL);
    assign hs_s       = (state_r == ST_SEND) && bus.tx_ready;
    // Fullness is judged before any same-cycle pop, and a flush swallows both the pop and the push.
    assign push_s     = push_req_s && !full_s && !flush_s;
    assign pop_s      = enable_r && !empty_s && !flush_s && ((state_r == ST_IDLE) || hs_s);
    assign unused_s   = ^bus.writedata[31:9];

    // FIFO storage; contents are only meaningful between rd_ptr and wr_ptr, so no reset.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= bus.writedata[8:0];
        end
    end

    // FIFO pointers and fill level.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            level_r  <= LVL_ZERO;
        end else if (flush_s) begin
            rd_ptr_r <= wr_ptr_r;
            level_r  <= LVL_ZERO;
        end else begin
            if (push_s) wr_ptr_r <= wr_ptr_r + AW'(1);
            if (pop_s)  rd_ptr_r <= rd_ptr_r + AW'(1);
            case ({push_s, pop_s})
                2'b10:   level_r <= level_r + LVL_ONE;
                2'b01:   level_r <= level_r - LVL_ONE;
                default: level_r <= level_r;
            endcase
        end
    end

    // Character sequencer: tx_data only moves on the IDLE->SEND load or on a handshake.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r   <= ST_IDLE;
            tx_data_r <= 9'h000;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (pop_s) begin
                        tx_data_r <= mem_r[rd_ptr_r];
                        state_r   <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    if (pop_s) begin
                        tx_data_r <= mem_r[rd_ptr_r];
                    end else if (hs_s) begin
                        state_r <= ST_IDLE;
                    end
                end
                default: state_r <= ST_IDLE;
            endcase
        end
    end

    // Control and sticky status registers; a new overflow wins over a same-cycle clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            enable_r   <= 1'b0;
            overflow_r <= 1'b0;
        end else begin
            if (ctrl_wr_s) enable_r <= bus.writedata[0];
            if (push_req_s && full_s) overflow_r <= 1'b1;
            else if (ovf_clr_s)      overflow_r <= 1'b0;
        end
    end

`ifdef SPW_TX_FIFO_IRQ_EN
    logic irq_en_r;
    logic irq_r;

    // Interrupt enable and registered interrupt request.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irq_en_r <= 1'b0;
            irq_r    <= 1'b0;
        end else begin
            if (ctrl_wr_s) irq_en_r <= bus.writedata[2];
            irq_r <= irq_en_r && (empty_s || overflow_r);
        end
    end

    assign irq_en_s = irq_en_r;
    assign irq      = irq_r;
`else
    assign irq_en_s = 1'b0;
`endif

    // Zero-wait-state register read mux.
    always_comb begin
        rdata_s = 32'h0000_0000;
        case (bus.address)
            2'd0: rdata_s = {23'h000000, tx_data_r};
            2'd1: begin
                rdata_s[8+AW:8] = level_r;
                rdata_s[3]      = (state_r == ST_SEND);
                rdata_s[2]      = overflow_r;
                rdata_s[1]      = full_s;
                rdata_s[0]      = empty_s;
            end
            2'd2:    rdata_s = {29'h00000000, irq_en_s, 1'b0, enable_r};
            default: rdata_s = 32'h0000_0000;
        endcase
    end

    assign bus.readdata = rdata_s;
    assign bus.tx_data  = tx_data_r;
    assign bus.tx_write = (state_r == ST_SEND);
endmodule

// File: tb/tb_spw_tx_data_sched.sv
// Bench for spw_tx_data_sched: directed scenarios plus random traffic against a queue-based reference model.
module tb_spw_tx_data_sched;
    localparam int DEPTH = 16;

    logic clk;
    logic reset_n;
`ifdef SPW_TX_FIFO_IRQ_EN
    logic irq;
`endif

    spw_tx_data_sched_if bus();

    spw_tx_data_sched #(.FIFO_DEPTH(DEPTH), .AW(4)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
`ifdef SPW_TX_FIFO_IRQ_EN
        ,
        .irq     (irq)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: characters waiting in the FIFO, the character on the link, and register state.
    logic [8:0] q[$];
    bit         m_busy;
    logic [8:0] m_data;
    bit         m_en, m_ovf, m_irq_en, m_irq;
    int         n_cmp;
    int         n_fail;

    function automatic logic [31:0] m_status();
        logic [31:0] s;
        s    = 32'(q.size()) << 8;
        s[3] = m_busy;
        s[2] = m_ovf;
        s[1] = (q.size() == DEPTH);
        s[0] = (q.size() == 0);
        return s;
    endfunction

    task automatic do_reset();
        bus.chipselect = 1'b0; bus.write_n = 1'b1; bus.address = 2'd1;
        bus.writedata = 32'h0; bus.tx_ready = 1'b0;
        reset_n = 1'b0;
        q.delete(); m_busy = 0; m_data = 9'h000; m_en = 0; m_ovf = 0; m_irq_en = 0; m_irq = 0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        #1;
    endtask

    // One clock: drive a bus access and tx_ready, advance the model across the edge, leave STATUS selected.
    task automatic cycle(input bit wr, input logic [1:0] a, input logic [31:0] d, input bit rdy);
        bit hs, fl, preq, pop, acc, pre_empty, pre_ovf;
        bus.tx_ready = rdy; bus.chipselect = wr; bus.write_n = !wr;
        bus.address = a; bus.writedata = d;
        hs   = m_busy && rdy;
        fl   = wr && (a == 2'd2) && d[1];
        preq = wr && (a == 2'd0);
        pop  = m_en && (q.size() != 0) && !fl && (!m_busy || hs);
        acc  = preq && (q.size() < DEPTH) && !fl;
        pre_empty = (q.size() == 0);
        pre_ovf   = m_ovf;
        @(posedge clk);
        m_irq = m_irq_en && (pre_empty || pre_ovf);
        if (preq && q.size() >= DEPTH) m_ovf = 1;
        else if (wr && (a == 2'd1) && d[2]) m_ovf = 0;
        if (fl) q.delete();
        if (pop) begin m_data = q.pop_front(); m_busy = 1; end
        else if (hs) m_busy = 0;
        if (acc) q.push_back(d[8:0]);
        if (wr && (a == 2'd2)) begin
            m_en = d[0];
`ifdef SPW_TX_FIFO_IRQ_EN
            m_irq_en = d[2];
`endif
        end
        @(negedge clk);
        bus.chipselect = 1'b0; bus.write_n = 1'b1; bus.address = 2'd1;
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++; if (bus.readdata !== 32'h0000_0001) begin n_fail++; $display("FAIL reset_status: got %h want %h", bus.readdata, 32'h1); end
        n_cmp++; if (bus.tx_write !== 1'b0) begin n_fail++; $display("FAIL reset_tx_write: got %b want 0", bus.tx_write); end
        n_cmp++; if (bus.tx_data !== 9'h000) begin n_fail++; $display("FAIL reset_tx_data: got %h want 000", bus.tx_data); end
        bus.address = 2'd2; #1;
        n_cmp++; if (bus.readdata !== 32'h0) begin n_fail++; $display("FAIL reset_ctrl: got %h want 0", bus.readdata); end
`ifdef SPW_TX_FIFO_IRQ_EN
        n_cmp++; if (irq !== 1'b0) begin n_fail++; $display("FAIL reset_irq: got %b want 0", irq); end
`endif
    endtask

    task automatic test_back_to_back();
        logic [8:0] pushes [3] = '{9'h041, 9'h142, 9'h043};
        bit         ew [5]     = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        logic [8:0] ed [5]     = '{9'h000, 9'h041, 9'h142, 9'h043, 9'h043};
        cycle(1, 2'd2, 32'h1, 1);
        for (int i = 0; i < 5; i++) begin
            if (i < 3) cycle(1, 2'd0, {23'h0, pushes[i]}, 1);
            else       cycle(0, 2'd0, 32'h0, 1);
            n_cmp++; if (bus.tx_write !== ew[i]) begin n_fail++; $display("FAIL burst_tx_write[%0d]: got %b want %b", i, bus.tx_write, ew[i]); end
            n_cmp++; if (bus.tx_data !== ed[i]) begin n_fail++; $display("FAIL burst_tx_data[%0d]: got %h want %h", i, bus.tx_data, ed[i]); end
        end
        n_cmp++; if (bus.readdata !== 32'h0000_0001) begin n_fail++; $display("FAIL burst_status: got %h want %h", bus.readdata, 32'h1); end
    endtask

    task automatic test_backpressure();
        cycle(1, 2'd0, 32'h0A5, 0);
        cycle(1, 2'd0, 32'h15A, 0);
        for (int i = 0; i < 10; i++) begin
            cycle(0, 2'd0, 32'h0, 0);
            n_cmp++; if (bus.tx_write !== 1'b1 || bus.tx_data !== 9'h0A5) begin n_fail++; $display("FAIL bp_hold[%0d]: got %b/%h want 1/0a5", i, bus.tx_write, bus.tx_data); end
            n_cmp++; if (bus.readdata !== 32'h0000_0108) begin n_fail++; $display("FAIL bp_status[%0d]: got %h want %h", i, bus.readdata, 32'h108); end
        end
        cycle(0, 2'd0, 32'h0, 1);
        n_cmp++; if (bus.tx_write !== 1'b1 || bus.tx_data !== 9'h15A) begin n_fail++; $display("FAIL bp_second: got %b/%h want 1/15a", bus.tx_write, bus.tx_data); end
        n_cmp++; if (bus.readdata !== 32'h0000_0009) begin n_fail++; $display("FAIL bp_status_drain: got %h want %h", bus.readdata, 32'h9); end
        cycle(0, 2'd0, 32'h0, 1);
        n_cmp++; if (bus.tx_write !== 1'b0) begin n_fail++; $display("FAIL bp_done: got %b want 0", bus.tx_write); end
    endtask

    task automatic test_overflow();
        int sent;
        cycle(1, 2'd2, 32'h0, 1);
        for (int i = 0; i < DEPTH + 1; i++) cycle(1, 2'd0, {23'h0, 9'($urandom)}, 1);
        n_cmp++; if (bus.readdata !== 32'h0000_1006) begin n_fail++; $display("FAIL ovf_status: got %h want %h", bus.readdata, 32'h1006); end
        cycle(1, 2'd1, 32'h4, 1);
        n_cmp++; if (bus.readdata !== 32'h0000_1002) begin n_fail++; $display("FAIL ovf_clear: got %h want %h", bus.readdata, 32'h1002); end
        cycle(1, 2'd2, 32'h1, 1);
        sent = 0;
        for (int i = 0; i < DEPTH + 4; i++) begin
            cycle(0, 2'd0, 32'h0, 1);
            if (bus.tx_write === 1'b1) sent++;
            n_cmp++; if (bus.tx_write !== m_busy || bus.tx_data !== m_data) begin n_fail++; $display("FAIL ovf_drain[%0d]: got %b/%h want %b/%h", i, bus.tx_write, bus.tx_data, m_busy, m_data); end
        end
        n_cmp++; if (sent != DEPTH) begin n_fail++; $display("FAIL ovf_sent_count: got %0d want %0d", sent, DEPTH); end
        n_cmp++; if (bus.readdata !== 32'h0000_0001) begin n_fail++; $display("FAIL ovf_final_status: got %h want %h", bus.readdata, 32'h1); end
    endtask

    task automatic test_flush();
        for (int i = 0; i < 5; i++) cycle(1, 2'd0, 32'h100 + 32'(i), 0);
        n_cmp++; if (bus.readdata !== 32'h0000_0408) begin n_fail++; $display("FAIL flush_pre_status: got %h want %h", bus.readdata, 32'h408); end
        cycle(1, 2'd2, 32'h2, 0);
        n_cmp++; if (bus.readdata !== 32'h0000_0009) begin n_fail++; $display("FAIL flush_status: got %h want %h", bus.readdata, 32'h9); end
        n_cmp++; if (bus.tx_write !== 1'b1 || bus.tx_data !== 9'h100) begin n_fail++; $display("FAIL flush_inflight: got %b/%h want 1/100", bus.tx_write, bus.tx_data); end
        bus.address = 2'd2; #1;
        n_cmp++; if (bus.readdata !== 32'h0) begin n_fail++; $display("FAIL flush_ctrl: got %h want 0", bus.readdata); end
        cycle(0, 2'd0, 32'h0, 1);
        n_cmp++; if (bus.tx_write !== 1'b0 || bus.readdata !== 32'h1) begin n_fail++; $display("FAIL flush_done: got %b/%h want 0/00000001", bus.tx_write, bus.readdata); end
        cycle(0, 2'd0, 32'h0, 1);
        n_cmp++; if (bus.tx_write !== 1'b0) begin n_fail++; $display("FAIL flush_idle: got %b want 0", bus.tx_write); end
    endtask

`ifdef SPW_TX_FIFO_IRQ_EN
    task automatic test_irq();
        cycle(1, 2'd2, 32'h4, 1);
        cycle(0, 2'd0, 32'h0, 1);
        n_cmp++; if (irq !== 1'b1) begin n_fail++; $display("FAIL irq_empty: got %b want 1", irq); end
        cycle(1, 2'd0, 32'h055, 1);
        cycle(0, 2'd0, 32'h0, 1);
        n_cmp++; if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_nonempty: got %b want 0", irq); end
        cycle(1, 2'd2, 32'h5, 1);
        n_cmp++; if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_before_pop: got %b want 0", irq); end
        cycle(0, 2'd0, 32'h0, 1);
        n_cmp++; if (irq !== 1'b0 || bus.readdata !== 32'h9) begin n_fail++; $display("FAIL irq_pop_cycle: got %b/%h want 0/00000009", irq, bus.readdata); end
        cycle(0, 2'd0, 32'h0, 1);
        n_cmp++; if (irq !== 1'b1) begin n_fail++; $display("FAIL irq_after_empty: got %b want 1", irq); end
        cycle(1, 2'd2, 32'h1, 1);
        cycle(0, 2'd0, 32'h0, 1);
        n_cmp++; if (irq !== m_irq || irq !== 1'b0) begin n_fail++; $display("FAIL irq_disabled: got %b want 0", irq); end
    endtask
`endif

    task automatic test_random();
        int r;
        bit rdy;
        for (int i = 0; i < 600; i++) begin
            r   = $urandom_range(0, 19);
            rdy = ($urandom_range(0, 99) < ((i < 300) ? 15 : 70));
            if (r < 10)       cycle(1, 2'd0, $urandom, rdy);
            else if (r == 10) cycle(1, 2'd2, {30'h0, ($urandom_range(0, 7) == 0), ($urandom_range(0, 3) != 0)}, rdy);
            else if (r == 11) cycle(1, 2'd1, 32'h4, rdy);
            else if (r == 12) cycle(1, 2'd3, $urandom, rdy);
            else              cycle(0, 2'd0, 32'h0, rdy);
            n_cmp++; if (bus.tx_write !== m_busy) begin n_fail++; $display("FAIL rand_tx_write[%0d]: got %b want %b", i, bus.tx_write, m_busy); end
            n_cmp++; if (bus.tx_data !== m_data) begin n_fail++; $display("FAIL rand_tx_data[%0d]: got %h want %h", i, bus.tx_data, m_data); end
            n_cmp++; if (bus.readdata !== m_status()) begin n_fail++; $display("FAIL rand_status[%0d]: got %h want %h", i, bus.readdata, m_status()); end
`ifdef SPW_TX_FIFO_IRQ_EN
            n_cmp++; if (irq !== m_irq) begin n_fail++; $display("FAIL rand_irq[%0d]: got %b want %b", i, irq, m_irq); end
`endif
        end
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        test_reset();
        test_back_to_back();
        test_backpressure();
        test_overflow();
        test_flush();
`ifdef SPW_TX_FIFO_IRQ_EN
        test_irq();
`endif
        test_random();
        test_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/spw_tx_data_sched.md
# spw_tx_data_sched

Avalon-MM slave that buffers 9-bit SpaceWire transmit characters (bit 8 = control flag, bits 7:0 = data) in a small FIFO. It sequences them onto the SpaceWire TX character interface with a write/ready handshake. It sits between the Nios bus and the SpaceWire link TX input, where a plain 9-bit output register would otherwise sit. Software can queue a burst of characters without polling per character.

## Interface
Parameters:
- FIFO_DEPTH, 16, number of character entries; power of 2, range 2..256.
- AW, 4, log2(FIFO_DEPTH); level counter width is AW+1.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- address  in  2  Avalon word address.
- chipselect  in  1  Avalon slave select.
- write_n  in  1  Avalon write strobe, active-low.
- writedata  in  32  Avalon write data.
- readdata  out  32  Avalon read data; combinational from address, zero wait states.
- tx_data  out  9  character presented to the link TX.
- tx_write  out  1  tx_data valid.
- tx_ready  in  1  link TX accepts the character this cycle.
- irq  out  1  present only with SPW_TX_FIFO_IRQ_EN.

## Operation
Register map. A write means chipselect && !write_n.
- addr 0 DATA
  - Write pushes writedata[8:0] into the FIFO.
  - Read returns {23'b0, tx_data}.
- addr 1 STATUS (read-only except bit 2)
  - bit0 empty, bit1 full, bit2 overflow (sticky).
  - bit3 busy: FSM is in SEND.
  - bits[8+AW:8] level.
  - Writing 1 to bit2 clears overflow.
- addr 2 CTRL (read/write)
  - bit0 enable.
  - bit1 flush: write-1 pulse, reads 0.
  - bit2 irq_en: read/write only with the macro; otherwise reads 0.
- addr 3: reads 0; writes ignored.

FIFO and overflow:
- A push when full (full evaluated before any same-cycle pop) is dropped and sets overflow. This holds even if a pop occurs in the same cycle.
- A simultaneous push and pop on a non-full FIFO leaves level unchanged.
- Read/write pointers wrap modulo FIFO_DEPTH.

FSM states:
- IDLE: tx_write=0. If enable && !empty: load head into tx_data, pop, go to SEND.
- SEND: tx_write=1, tx_data held stable. On tx_ready:
  - if enable && !empty: load the next head, pop, and stay in SEND (back-to-back characters);
  - otherwise go to IDLE.
- Clearing enable during SEND does not abort the character. It completes on tx_ready, then the FSM returns to IDLE.
- Flush sets level to 0 and rd_ptr = wr_ptr. It does not abort a character already in SEND. A push in the same cycle as a flush is discarded.

## Timing
- Reset values:
  - tx_data=0, tx_write=0, readdata follows the reset register values.
  - Level 0, empty=1, overflow=0, enable=0, irq_en=0, irq=0, FSM in IDLE.
- Latency: a DATA push at edge N on an empty, enabled FIFO gives tx_write=1 and valid tx_data after edge N+1.
- Throughput: one character per cycle while tx_ready stays high and the FIFO is non-empty.
- tx_data changes only on a handshake or on the IDLE->SEND load.
- Status bits update on the edge after the push or pop that changes them.
- Reset asserted mid-SEND: tx_write drops asynchronously and FIFO contents are lost.

## Configuration
- SPW_TX_FIFO_IRQ_EN defined:
  - irq port and CTRL bit2 exist.
  - irq = irq_en && (empty || overflow), registered (one cycle after the condition).
- SPW_TX_FIFO_IRQ_EN undefined:
  - No irq port; CTRL bit2 reads 0.
  - All other behaviour is identical.

## Test plan
- Reset:
  - Stimulus: reset, then read addr 1.
  - Required: STATUS = 0x00000001; tx_write=0; tx_data=0.
- Back-to-back burst:
  - Stimulus: enable=1, tx_ready held 1, push 0x041, 0x142, 0x043 on consecutive cycles.
  - Required: tx_data sequence 0x041, 0x142, 0x043 on three consecutive handshake cycles; first valid one cycle after the first push; tx_write low afterwards.
- Backpressure:
  - Stimulus: tx_ready=0 for 10 cycles with 2 entries queued.
  - Required: tx_data stable at the first entry, tx_write=1, level=1 throughout; drains correctly once tx_ready=1.
- Overflow:
  - Stimulus: enable=0, push 17 words with FIFO_DEPTH=16.
  - Required: full=1, level=16, overflow=1; the 17th word is never transmitted. Writing 0x4 to addr 1 clears overflow.
- Flush and enable during SEND:
  - Stimulus: 5 entries queued, tx_ready=0; then write CTRL=0x2 (flush, enable cleared); then raise tx_ready.
  - Required: in-flight character completes; level=0; tx_write=0 afterwards.
- IRQ (macro defined):
  - Stimulus: irq_en=1, push and drain one word.
  - Required: irq=0 while non-empty; irq=1 one cycle after empty.
